mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the CPU core and the single-port, 8-bit-wide unified RAM. It arbitrates between the instruction-fetch stage (word reads) and the memory-access stage (byte/half/word reads and writes). It sequences one RAM byte per cycle and returns assembled little-endian data with a one-cycle done pulse. It also publishes which requester it is currently serving, so the fetch stage can stall or retry.

## Interface
- RAM_ADDR_W, 32, width of the RAM address bus; the upper bits of the internal 32-bit address are dropped.
- IO_BASE, 32'h0003_0000, first address of the memory-mapped I/O window; addresses at or above it are I/O.
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; one clock, asynchronous, active-low (polarity and synchronicity fixed).
- if_req_in  input  1  fetch request; level-held until done or abort.
- if_addr_in  input  32  fetch address.
- mem_req_in  input  1  memory-stage request; level-held until done.
- mem_we_in  input  1  1 = write, 0 = read.
- mem_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr_in  input  32  data address.
- mem_data_in  input  32  write data; low bytes are used.
- busy_out  output  2  bit0 = MEM transaction active, bit1 = IF transaction active.
- inst_done_out  output  1  one-cycle pulse; inst_out valid.
- inst_out  output  32  assembled instruction.
- mem_done_out  output  1  one-cycle pulse; load data valid, or store complete.
- mem_data_out  output  32  load data, zero-extended.
- ram_a_out  output  RAM_ADDR_W  RAM byte address.
- ram_wr_out  output  1  RAM write enable.
- ram_dout_out  output  8  RAM write byte.
- ram_din_in  input  8  RAM read byte; valid the cycle after its address edge.

## Operation
- State machine states: IDLE, READ, WRITE.
- Owner flag: IF or MEM.
- Byte counter cnt[2:0]; length N = 1, 2 or 4 (IF is always 4).
- IDLE:
  - If mem_req_in is high, start a MEM transaction; READ or WRITE is chosen by mem_we_in.
  - Otherwise, if if_req_in is high, start an IF READ.
  - MEM wins any simultaneous request.
  - Address, size and write data are latched at acceptance.
- Transactions are non-preemptible, with one exception: if if_req_in is low during an IF READ (branch flush), the controller returns to IDLE at the next edge. In that case there is no inst_done_out pulse and the partial data is discarded.
- READ:
  - ram_a_out = base + cnt.
  - Byte k is captured from ram_din_in into bits [8k+7:8k] on the edge after address k is driven.
  - After byte N-1 is captured, drive done and data, then return to IDLE.
- WRITE:
  - ram_wr_out = 1.
  - ram_a_out = base + cnt.
  - ram_dout_out = data byte cnt.
  - After byte N-1 has been presented for one cycle, drop ram_wr_out, pulse mem_done_out, then return to IDLE.
- Address arithmetic wraps modulo 2^32 before truncation to RAM_ADDR_W.
- Unused upper bytes of mem_data_out are 0; sign extension is not done here.
- busy_out is 2'b01 for a MEM owner and 2'b10 for an IF owner while in READ or WRITE. It is 2'b00 in IDLE, including the done cycle.
- inst_out and mem_data_out hold their value until the next done of the same type.

## Timing
- All outputs are registered.
- Reset values: busy_out = 0, inst_done_out = 0, inst_out = 0, mem_done_out = 0, mem_data_out = 0, ram_a_out = 0, ram_wr_out = 0, ram_dout_out = 0, state = IDLE.
- Request sampled at edge E0 → first RAM address is driven in the cycle after E0.
- Done pulse is high in the cycle after edge E_N, i.e. N+1 cycles after acceptance: word = 5 cycles, half = 3 cycles, byte = 2 cycles. This applies to both reads and writes.
- The done cycle is in IDLE, so a new request can be accepted at the following edge. Back-to-back throughput is N+1 cycles per transaction.
- Requesters must drop their request combinationally on their done. A request still high in the done cycle is treated as a new transaction.
- Asynchronous reset mid-transaction clears everything immediately. ram_wr_out falls without waiting for a clock, and no done pulse is produced.

## Configuration
- MEMCTRL_IO_STALL_EN defined:
  - Adds input io_buffer_full_in (1 bit).
  - During WRITE to an address at or above IO_BASE, while io_buffer_full_in is high: ram_wr_out = 0 and cnt is frozen.
  - The byte is re-presented once io_buffer_full_in is low. Latency grows by one cycle per stalled cycle.
- MEMCTRL_IO_STALL_EN undefined: the port is absent and I/O writes never stall.

## Structure
- defines.v holds:
  - State encodings IDLE/READ/WRITE.
  - Size encodings.
  - Owner encodings.
  - The IO_BASE default.
  - Busy bit indices.
- Single module; no sub-module is needed. Byte-lane insert and extract stay inline.

## Test plan
- Reset, then IF word read at 0x0000_0004 with RAM bytes 13, 00, 00, 00:
  - ram_a_out goes 4, 5, 6, 7.
  - inst_done_out pulses 5 cycles after acceptance.
  - inst_out = 0x0000_0013.
  - busy_out = 2'b10 for cycles 1–4.
- Simultaneous IF and MEM (load byte at 0x100) requests → MEM served first (busy_out = 2'b01); mem_done_out arrives 2 cycles after acceptance; IF is then accepted on the following edge.
- Store half 0xABCD to 0x200 → two writes: 0x200 ← CD, then 0x201 ← AB; mem_done_out arrives 3 cycles after acceptance; ram_wr_out is low in the done cycle.
- IF read with if_req_in dropped after 2 bytes → state returns to IDLE; no inst_done_out; inst_out is unchanged.
- rst_n_in asserted mid-word-write → ram_wr_out drops asynchronously; all outputs take their reset values; a subsequent load behaves normally.
- With MEMCTRL_IO_STALL_EN, byte store to 0x30000 with io_buffer_full_in high for 3 cycles → ram_wr_out is held low for those cycles; mem_done_out arrives 5 cycles after acceptance.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and transaction payload for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h0003_0000;

  localparam int unsigned BUSY_MEM = 0;
  localparam int unsigned BUSY_IF  = 1;
  localparam logic [1:0]  BUSY_MEM_V = 2'(1 << BUSY_MEM);
  localparam logic [1:0]  BUSY_IF_V  = 2'(1 << BUSY_IF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD3 = 2'b11
  } size_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Transaction latched at acceptance
  typedef struct packed {
    owner_t             owner;
    logic [CNT_W-1:0]   last;
    logic [ADDR_W-1:0]  base;
    logic [DATA_W-1:0]  wdata;
  } txn_t;

  // Index of the final byte for a given access size
  function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] size);
    case (size_t'(size))
      SZ_BYTE: return CNT_W'(0);
      SZ_HALF: return CNT_W'(1);
      default: return CNT_W'(3);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller arbitrating fetch and memory-stage accesses to an 8-bit RAM.
// Optional MEMCTRL_IO_STALL_EN holds I/O-window writes while io_buffer_full_in is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 32
`ifdef MEMCTRL_IO_STALL_EN
  ,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  if_req_in,
  input  logic [ADDR_W-1:0]     if_addr_in,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_size_in,
  input  logic [ADDR_W-1:0]     mem_addr_in,
  input  logic [DATA_W-1:0]     mem_data_in,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic                  io_buffer_full_in,
`endif
  output logic [1:0]            busy_out,
  output logic                  inst_done_out,
  output logic [DATA_W-1:0]     inst_out,
  output logic                  mem_done_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic [RAM_ADDR_W-1:0] ram_a_out,
  output logic                  ram_wr_out,
  output logic [BYTE_W-1:0]     ram_dout_out,
  input  logic [BYTE_W-1:0]     ram_din_in
);

  state_t            state;
  txn_t              txn;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;

  logic [CNT_W-1:0]  cnt_nx_c;
  logic [ADDR_W-1:0] next_addr_c;
  logic [DATA_W-1:0] rdata_c;
  logic [BYTE_W-1:0] next_byte_c;
  logic              last_c;
  logic              stall_acc_c;
  logic              stall_cur_c;
  logic              stall_nx_c;

  assign cnt_nx_c    = cnt + CNT_W'(1);
  assign next_addr_c = txn.base + ADDR_W'(cnt_nx_c);
  assign last_c      = (cnt == txn.last);
  // Bytes above cnt are still zero, so OR-ing in the current byte yields zero-extended data
  assign rdata_c     = data_q | (DATA_W'(ram_din_in) << {cnt, 3'b000});
  assign next_byte_c = BYTE_W'(txn.wdata >> {cnt_nx_c, 3'b000});

`ifdef MEMCTRL_IO_STALL_EN
  assign stall_acc_c = (mem_addr_in >= IO_BASE) && io_buffer_full_in;
  assign stall_cur_c = ((txn.base + ADDR_W'(cnt)) >= IO_BASE) && io_buffer_full_in;
  assign stall_nx_c  = (next_addr_c >= IO_BASE) && io_buffer_full_in;
`else
  assign stall_acc_c = 1'b0;
  assign stall_cur_c = 1'b0;
  assign stall_nx_c  = 1'b0;
`endif

  // Transaction sequencer; every output is a register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      txn           <= '0;
      cnt           <= '0;
      data_q        <= '0;
      busy_out      <= '0;
      inst_done_out <= 1'b0;
      inst_out      <= '0;
      mem_done_out  <= 1'b0;
      mem_data_out  <= '0;
      ram_a_out     <= '0;
      ram_wr_out    <= 1'b0;
      ram_dout_out  <= '0;
    end else begin
      inst_done_out <= 1'b0;
      mem_done_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt        <= '0;
          data_q     <= '0;
          ram_wr_out <= 1'b0;
          if (mem_req_in) begin
            txn          <= '{owner: OWN_MEM, last: last_idx(mem_size_in),
                              base: mem_addr_in, wdata: mem_data_in};
            state        <= mem_we_in ? ST_WRITE : ST_READ;
            busy_out     <= BUSY_MEM_V;
            ram_a_out    <= RAM_ADDR_W'(mem_addr_in);
            ram_wr_out   <= mem_we_in && !stall_acc_c;
            ram_dout_out <= mem_data_in[BYTE_W-1:0];
          end else if (if_req_in) begin
            txn       <= '{owner: OWN_IF, last: CNT_W'(3), base: if_addr_in, wdata: '0};
            state     <= ST_READ;
            busy_out  <= BUSY_IF_V;
            ram_a_out <= RAM_ADDR_W'(if_addr_in);
          end
        end
        ST_READ: begin
          if (txn.owner == OWN_IF && !if_req_in) begin
            // Branch flush: abandon the fetch without a done pulse
            state    <= ST_IDLE;
            busy_out <= '0;
          end else if (last_c) begin
            state    <= ST_IDLE;
            busy_out <= '0;
            if (txn.owner == OWN_IF) begin
              inst_out      <= rdata_c;
              inst_done_out <= 1'b1;
            end else begin
              mem_data_out <= rdata_c;
              mem_done_out <= 1'b1;
            end
          end else begin
            data_q    <= rdata_c;
            cnt       <= cnt_nx_c;
            ram_a_out <= RAM_ADDR_W'(next_addr_c);
          end
        end
        ST_WRITE: begin
          if (ram_wr_out) begin
            if (last_c) begin
              state        <= ST_IDLE;
              busy_out     <= '0;
              ram_wr_out   <= 1'b0;
              mem_done_out <= 1'b1;
            end else begin
              cnt          <= cnt_nx_c;
              ram_a_out    <= RAM_ADDR_W'(next_addr_c);
              ram_dout_out <= next_byte_c;
              ram_wr_out   <= !stall_nx_c;
            end
          end else begin
            // Byte held back by a full I/O buffer; re-present once it drains
            ram_wr_out <= !stall_cur_c;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected bus cycles and done results,
// a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  busy;
  logic        inst_done;
  logic [31:0] inst;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
`ifdef MEMCTRL_IO_STALL_EN
  logic        io_full;
`endif

  mem_ctrl dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .if_req_in     (if_req),
    .if_addr_in    (if_addr),
    .mem_req_in    (mem_req),
    .mem_we_in     (mem_we),
    .mem_size_in   (mem_size),
    .mem_addr_in   (mem_addr),
    .mem_data_in   (mem_data),
`ifdef MEMCTRL_IO_STALL_EN
    .io_buffer_full_in (io_full),
`endif
    .busy_out      (busy),
    .inst_done_out (inst_done),
    .inst_out      (inst),
    .mem_done_out  (mem_done),
    .mem_data_out  (mem_rdata),
    .ram_a_out     (ram_a),
    .ram_wr_out    (ram_wr),
    .ram_dout_out  (ram_dout),
    .ram_din_in    (ram_din)
  );

  bit [7:0] ram [0:4095];
  assign ram_din = ram[ram_a[11:0]];

  typedef struct {
    logic [1:0]  busy;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } done_t;

  bus_t  bus_q[$];
  done_t inst_q[$];
  done_t mem_q[$];
  int    cyc;
  int    n_checks;
  int    n_fail;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void exp_rd(logic [1:0] b, logic [31:0] base, int n);
    for (int k = 0; k < n; k++) bus_q.push_back('{b, 1'b0, base + 32'(k), 8'h00});
  endfunction

  function automatic void exp_wr(logic [31:0] base, logic [31:0] d, int n);
    for (int k = 0; k < n; k++) bus_q.push_back('{2'b01, 1'b1, base + 32'(k), 8'(d >> (8 * k))});
  endfunction

  function automatic void exp_done(bit is_if, logic [31:0] d, int at, bit chk);
    if (is_if) inst_q.push_back('{d, at, chk});
    else       mem_q.push_back('{d, at, chk});
  endfunction

  // Pop and compare whatever the DUT presents this cycle; also model the RAM write port
  task automatic monitor();
    bus_t  b;
    done_t d;
    if (busy != 2'b00) begin
      if (bus_q.size() == 0) check("bus_unexpected", {30'd0, busy}, 32'd0);
      else begin
        b = bus_q.pop_front();
        check("bus_busy", {30'd0, busy}, {30'd0, b.busy});
        check("bus_wr", {31'd0, ram_wr}, {31'd0, b.wr});
        check("bus_addr", ram_a, b.addr);
        if (b.wr) check("bus_dout", {24'd0, ram_dout}, {24'd0, b.dout});
      end
    end
    if (inst_done) begin
      if (inst_q.size() == 0) check("inst_done_unexpected", inst, 32'd0);
      else begin
        d = inst_q.pop_front();
        check("inst_data", inst, d.data);
        check("inst_latency", 32'(cyc), 32'(d.cyc));
      end
    end
    if (mem_done) begin
      if (mem_q.size() == 0) check("mem_done_unexpected", mem_rdata, 32'd0);
      else begin
        d = mem_q.pop_front();
        if (d.chk_data) check("mem_data", mem_rdata, d.data);
        check("mem_latency", 32'(cyc), 32'(d.cyc));
        check("wr_low_in_done", {31'd0, ram_wr}, 32'd0);
      end
    end
    if (ram_wr) ram[ram_a[11:0]] = ram_dout;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_if, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sync();
      if (is_if ? inst_done : mem_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_if(input logic [31:0] a);
    bit ok;
    if_addr = a;
    if_req  = 1'b1;
    wait_done(1'b1, ok);
    if_req  = 1'b0;
    check("if_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    bit ok;
    mem_we   = we;
    mem_size = sz;
    mem_addr = a;
    mem_data = d;
    mem_req  = 1'b1;
    wait_done(1'b0, ok);
    mem_req  = 1'b0;
    check("mem_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, {30'd0, busy}, 32'd0);
    check({tag, "_wr"}, {31'd0, ram_wr}, 32'd0);
    check({tag, "_addr"}, ram_a, 32'd0);
    check({tag, "_dout"}, {24'd0, ram_dout}, 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_mdata"}, mem_rdata, 32'd0);
    check({tag, "_dones"}, {30'd0, inst_done, mem_done}, 32'd0);
  endtask

  task automatic run_tests();
    int c;
    ram[12'h004] = 8'h13; ram[12'h005] = 8'h00; ram[12'h006] = 8'h00; ram[12'h007] = 8'h00;
    ram[12'h010] = 8'h78; ram[12'h011] = 8'h56; ram[12'h012] = 8'h34; ram[12'h013] = 8'h12;
    ram[12'h100] = 8'hA5; ram[12'h101] = 8'hFF;
    ram[12'h202] = 8'h77; ram[12'h203] = 8'h77;
    ram[12'h040] = 8'hDE; ram[12'h041] = 8'hAD; ram[12'h042] = 8'hBE; ram[12'h043] = 8'hEF;

    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    sync();

    // Fetches: little-endian assembly
    c = cyc; exp_rd(2'b10, 32'h4, 4);  exp_done(1'b1, 32'h0000_0013, c + 5, 1'b1);
    do_if(32'h4);
    sync();
    c = cyc; exp_rd(2'b10, 32'h10, 4); exp_done(1'b1, 32'h1234_5678, c + 5, 1'b1);
    do_if(32'h10);
    sync();

    // Simultaneous requests: MEM byte load first, IF accepted right after its done cycle
    c = cyc;
    exp_rd(2'b01, 32'h100, 1); exp_done(1'b0, 32'h0000_00A5, c + 2, 1'b1);
    exp_rd(2'b10, 32'h10, 4);  exp_done(1'b1, 32'h1234_5678, c + 7, 1'b1);
    fork
      do_if(32'h10);
      do_mem(1'b0, 2'b00, 32'h100, 32'h0);
    join
    sync();

    // Half store uses only the low two bytes
    c = cyc; exp_wr(32'h200, 32'h1234_ABCD, 2); exp_done(1'b0, 32'h0, c + 3, 1'b0);
    do_mem(1'b1, 2'b01, 32'h200, 32'h1234_ABCD);
    c = cyc; exp_rd(2'b01, 32'h200, 4); exp_done(1'b0, 32'h7777_ABCD, c + 5, 1'b1);
    do_mem(1'b0, 2'b10, 32'h200, 32'h0);
    c = cyc; exp_wr(32'h300, 32'hDEAD_BEEF, 4); exp_done(1'b0, 32'h0, c + 5, 1'b0);
    do_mem(1'b1, 2'b10, 32'h300, 32'hDEAD_BEEF);
    c = cyc; exp_rd(2'b01, 32'h302, 2); exp_done(1'b0, 32'h0000_DEAD, c + 3, 1'b1);
    do_mem(1'b0, 2'b01, 32'h302, 32'h0);
    c = cyc; exp_rd(2'b01, 32'h300, 4); exp_done(1'b0, 32'hDEAD_BEEF, c + 5, 1'b1);
    do_mem(1'b0, 2'b11, 32'h300, 32'h0);
    sync();

    // Fetch flushed after two bytes captured
    exp_rd(2'b10, 32'h40, 3);
    if_addr = 32'h40;
    if_req  = 1'b1;
    repeat (3) sync();
    if_req  = 1'b0;
    repeat (3) sync();
    check("flush_inst_held", inst, 32'h1234_5678);
    check("flush_idle", {30'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a word store
    exp_wr(32'h320, 32'h1122_3344, 1);
    mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h320; mem_data = 32'h1122_3344;
    mem_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    mem_req = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    sync();
    c = cyc; exp_rd(2'b01, 32'h100, 2); exp_done(1'b0, 32'h0000_FFA5, c + 3, 1'b1);
    do_mem(1'b0, 2'b01, 32'h100, 32'h0);
    sync();

`ifdef MEMCTRL_IO_STALL_EN
    // I/O byte store held off for three cycles by a full buffer
    c = cyc;
    for (int k = 0; k < 3; k++) bus_q.push_back('{2'b01, 1'b0, 32'h0003_0000, 8'h5A});
    exp_wr(32'h0003_0000, 32'h5A, 1);
    exp_done(1'b0, 32'h0, c + 5, 1'b0);
    io_full = 1'b1;
    fork
      do_mem(1'b1, 2'b00, 32'h0003_0000, 32'h5A);
      begin
        repeat (3) sync();
        io_full = 1'b0;
      end
    join
    sync();
`endif
    repeat (3) sync();
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = '0; mem_addr = '0; mem_data = '0;
`ifdef MEMCTRL_IO_STALL_EN
    io_full = 1'b0;
`endif
    cyc = 0; n_checks = 0; n_fail = 0;
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        monitor();
      end
      run_tests();
      begin
        #200000;
        check("global_timeout", 32'd0, 32'd1);
      end
    join_any
    disable fork;
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("inst_q_drained", 32'(inst_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
